// File: rtl/cv32e40x_lsu_split_sequencer_pkg.sv
// Shared types and encodings for the LSU split sequencer slice.
package cv32e40x_lsu_split_sequencer_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  memtype;
  } obi_data_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [0:0]  err;
  } obi_data_resp_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] split_state_e;
  localparam split_state_e IDLE   = 2'd0;
  localparam split_state_e ISSUE2 = 2'd1;
  localparam split_state_e WAIT   = 2'd2;
  localparam split_state_e REJECT = 2'd3;

  // Size 2'b11 is illegal and handled as a full word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'h1;
      SIZE_HALF: return 4'h3;
      default:   return 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/cv32e40x_lsu_split_merge.sv
// Byte-enable / store-data rotation for outgoing transfers and
// load-data merge plus sign/zero extension for the returning response.
module cv32e40x_lsu_split_merge
  import cv32e40x_lsu_split_sequencer_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic        split,
  output logic [31:0] wdata_rot,
  input  logic [1:0]  rsp_off,
  input  logic [1:0]  rsp_size,
  input  logic        rsp_sext,
  input  logic        rsp_we,
  input  logic        rsp_split,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [31:0] rdata
);

  logic [7:0]  be64;
  logic [4:0]  wsh;
  logic [4:0]  rsh;
  logic [31:0] d32;

  always_comb begin
    be64  = {4'h0, size_mask(req_size)} << req_off;
    be_lo = be64[3:0];
    be_hi = be64[7:4];
    split = |be64[7:4];

    wsh       = {req_off, 3'b000};
    wdata_rot = (req_wdata << wsh) | (req_wdata >> (6'd32 - {1'b0, wsh}));

    // Aligned accesses only have the low word; the upper half reads as zero.
    rsh = {rsp_off, 3'b000};
    d32 = 32'({(rsp_split ? rdata_hi : 32'h0), rdata_lo} >> rsh);

    case (rsp_size)
      SIZE_BYTE: rdata = {{24{rsp_sext & d32[7]}}, d32[7:0]};
      SIZE_HALF: rdata = {{16{rsp_sext & d32[15]}}, d32[15:0]};
      default:   rdata = d32;
    endcase
    if (rsp_we) rdata = 32'h0;
  end

endmodule

// File: rtl/cv32e40x_lsu_split_sequencer.sv
// Turns one LSU request into one or two OBI transfers and merges the
// returning responses into a single LSU response.
//
// state  | meaning
// IDLE   | ready for a request; transfer 1 driven combinationally
// ISSUE2 | holding transfer 2 (high word) until accepted
// WAIT   | all transfers issued, counting outstanding responses
// REJECT | one-cycle error response for a refused misaligned access
module cv32e40x_lsu_split_sequencer
  import cv32e40x_lsu_split_sequencer_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [31:0]    addr_i,
  input  logic           we_i,
  input  logic [1:0]     size_i,
  input  logic           sext_i,
  input  logic [31:0]    wdata_i,
  input  logic [1:0]     memtype_i,
  output logic           trans_valid_o,
  input  logic           trans_ready_i,
  output obi_data_req_t  trans_o,
  input  logic           resp_valid_i,
  input  obi_data_resp_t resp_i,
  output logic           resp_valid_o,
  output logic [31:0]    rdata_o,
  output logic           err_o,
  output logic           misaligned_o,
  output logic           busy_o
);

  split_state_e  state_q, state_d;
  logic [1:0]    resp_cnt_q, resp_cnt_d;
  logic [1:0]    off_q;
  logic [1:0]    size_q;
  logic          sext_q;
  logic          we_q;
  logic          split_q;
  obi_data_req_t trans2_q;
  logic [31:0]   rdata_lo_q;
  logic          err_acc_q;

  logic [3:0]    be_lo, be_hi;
  logic          split;
  logic [31:0]   wdata_rot;
  logic [31:0]   merged_rdata;
  logic          reject;
  logic          accept;
  logic          resp_active;

  cv32e40x_lsu_split_merge u_merge (
    .req_off   (addr_i[1:0]),
    .req_size  (size_i),
    .req_wdata (wdata_i),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .split     (split),
    .wdata_rot (wdata_rot),
    .rsp_off   (off_q),
    .rsp_size  (size_q),
    .rsp_sext  (sext_q),
    .rsp_we    (we_q),
    .rsp_split (split_q),
    .rdata_lo  (split_q ? rdata_lo_q : resp_i.rdata),
    .rdata_hi  (resp_i.rdata),
    .rdata     (merged_rdata)
  );

  assign reject      = !ALLOW_MISALIGNED && split;
  assign accept      = (state_q == IDLE) && valid_i && ready_o;
  assign resp_active = (state_q == ISSUE2) || (state_q == WAIT);
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    resp_cnt_d    = resp_cnt_q;
    ready_o       = 1'b0;
    trans_valid_o = 1'b0;
    trans_o       = trans2_q;
    resp_valid_o  = 1'b0;
    rdata_o       = 32'h0;
    err_o         = 1'b0;
    misaligned_o  = 1'b0;

    case (state_q)
      IDLE: begin
        trans_o = '{addr: {addr_i[31:2], 2'b00}, we: we_i, be: be_lo,
                    wdata: wdata_rot, memtype: memtype_i};
        if (reject) begin
          ready_o = 1'b1;
          if (valid_i) state_d = REJECT;
        end else begin
          ready_o       = trans_ready_i;
          trans_valid_o = valid_i;
          if (valid_i && trans_ready_i) begin
            state_d    = split ? ISSUE2 : WAIT;
            resp_cnt_d = split ? 2'd2 : 2'd1;
          end
        end
      end
      ISSUE2: begin
        trans_valid_o = 1'b1;
        if (trans_ready_i) state_d = WAIT;
      end
      REJECT: begin
        resp_valid_o = 1'b1;
        err_o        = 1'b1;
        misaligned_o = 1'b1;
        state_d      = IDLE;
      end
      default: ;
    endcase

    // The low-word response may already arrive while transfer 2 is pending.
    if (resp_active && resp_valid_i && (resp_cnt_q != 2'd0)) begin
      resp_cnt_d = resp_cnt_q - 2'd1;
      if (resp_cnt_q == 2'd1) begin
        resp_valid_o = 1'b1;
        rdata_o      = merged_rdata;
        err_o        = err_acc_q | resp_i.err[0];
        misaligned_o = split_q;
        state_d      = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      resp_cnt_q <= 2'd0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      trans2_q   <= '0;
      rdata_lo_q <= 32'h0;
      err_acc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_cnt_q <= resp_cnt_d;
      if (accept) begin
        off_q      <= addr_i[1:0];
        size_q     <= size_i;
        sext_q     <= sext_i;
        we_q       <= we_i;
        split_q    <= split;
        trans2_q   <= '{addr: {addr_i[31:2], 2'b00} + 32'd4, we: we_i, be: be_hi,
                        wdata: wdata_rot, memtype: memtype_i};
        rdata_lo_q <= 32'h0;
        err_acc_q  <= 1'b0;
      end else if (resp_active && resp_valid_i && (resp_cnt_q == 2'd2)) begin
        rdata_lo_q <= resp_i.rdata;
        err_acc_q  <= resp_i.err[0];
      end
    end
  end

  a_no_cnt_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    (resp_valid_i && resp_active) |-> (resp_cnt_q != 2'd0));

  a_no_resp_in_idle : assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid_i |-> (state_q != IDLE));

  a_trans_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (trans_valid_o && !trans_ready_i) |=> (trans_valid_o && $stable(trans_o)));

endmodule

// File: tb/tb_cv32e40x_lsu_split_sequencer.sv
// Directed bench with scoreboard queues for transfers and merged responses.
module tb_cv32e40x_lsu_split_sequencer;
  import cv32e40x_lsu_split_sequencer_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } rsp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid = 1'b0, valid_nm = 1'b0;
  logic           ready, ready_nm;
  logic [31:0]    addr = '0;
  logic           we = 1'b0;
  logic [1:0]     size = 2'b10;
  logic           sext = 1'b0;
  logic [31:0]    wdata = '0;
  logic [1:0]     memtype = '0;
  logic           trans_valid, trans_valid_nm;
  logic           trans_ready = 1'b0;
  obi_data_req_t  trans, trans_nm;
  logic           resp_valid = 1'b0;
  obi_data_resp_t resp = '0;
  logic           rvalid, rvalid_nm;
  logic [31:0]    rdata, rdata_nm;
  logic           err, err_nm, mis, mis_nm, busy, busy_nm;

  int n_cmp = 0;
  int n_bad = 0;

  obi_data_req_t exp_trans[$];
  rsp_t          exp_rsp[$];
  rsp_t          exp_rsp_nm[$];

  always #5 clk = ~clk;

  cv32e40x_lsu_split_sequencer #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid), .ready_o(ready), .addr_i(addr),
    .we_i(we), .size_i(size), .sext_i(sext), .wdata_i(wdata), .memtype_i(memtype),
    .trans_valid_o(trans_valid), .trans_ready_i(trans_ready), .trans_o(trans),
    .resp_valid_i(resp_valid), .resp_i(resp), .resp_valid_o(rvalid), .rdata_o(rdata),
    .err_o(err), .misaligned_o(mis), .busy_o(busy)
  );

  cv32e40x_lsu_split_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_nm), .ready_o(ready_nm), .addr_i(addr),
    .we_i(we), .size_i(size), .sext_i(sext), .wdata_i(wdata), .memtype_i(memtype),
    .trans_valid_o(trans_valid_nm), .trans_ready_i(1'b1), .trans_o(trans_nm),
    .resp_valid_i(1'b0), .resp_i('0), .resp_valid_o(rvalid_nm), .rdata_o(rdata_nm),
    .err_o(err_nm), .misaligned_o(mis_nm), .busy_o(busy_nm)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Monitor: peeks the head transfer every valid cycle, pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trans_valid) begin
        if (exp_trans.size() == 0) fail_now("trans_unexpected", $sformatf("got addr %0h be %0h, expected none", trans.addr, trans.be));
        else begin
          chk("trans_addr", trans.addr, exp_trans[0].addr);
          chk("trans_we", trans.we, exp_trans[0].we);
          chk("trans_be", trans.be, exp_trans[0].be);
          chk("trans_wdata", trans.wdata, exp_trans[0].wdata);
          chk("trans_memtype", trans.memtype, exp_trans[0].memtype);
          if (trans_ready) void'(exp_trans.pop_front());
        end
      end
      if (rvalid) begin
        if (exp_rsp.size() == 0) fail_now("resp_unexpected", $sformatf("got rdata %0h, expected none", rdata));
        else begin
          chk("resp_rdata", rdata, exp_rsp[0].rdata);
          chk("resp_err", err, exp_rsp[0].err);
          chk("resp_mis", mis, exp_rsp[0].mis);
          void'(exp_rsp.pop_front());
        end
      end
      if (trans_valid_nm) fail_now("nm_trans_unexpected", $sformatf("got addr %0h, expected no transfer", trans_nm.addr));
      if (rvalid_nm) begin
        if (exp_rsp_nm.size() == 0) fail_now("nm_resp_unexpected", "got response, expected none");
        else begin
          chk("nm_resp_rdata", rdata_nm, exp_rsp_nm[0].rdata);
          chk("nm_resp_err", err_nm, exp_rsp_nm[0].err);
          chk("nm_resp_mis", mis_nm, exp_rsp_nm[0].mis);
          void'(exp_rsp_nm.pop_front());
        end
      end
    end
  end

  task automatic pt(input logic [31:0] a, input logic w, input logic [3:0] b,
                    input logic [31:0] d, input logic [1:0] m);
    exp_trans.push_back('{addr: a, we: w, be: b, wdata: d, memtype: m});
  endtask

  task automatic pr(input logic [31:0] d, input logic e, input logic m);
    exp_rsp.push_back('{rdata: d, err: e, mis: m});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic req(input logic [31:0] a, input logic w, input logic [1:0] sz,
                     input logic sx, input logic [31:0] wd, input logic [1:0] mt);
    bit done = 1'b0;
    addr = a; we = w; size = sz; sext = sx; wdata = wd; memtype = mt; valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      done = ready;
    end
    if (!done) fail_now("req_accept_timeout", $sformatf("addr %0h not accepted within 20 cycles", a));
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] d, input logic e);
    resp_valid = 1'b1;
    resp.rdata = d;
    resp.err   = e;
    @(posedge clk); #1;
    resp_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = (exp_trans.size() == 0) && (exp_rsp.size() == 0) &&
             (exp_rsp_nm.size() == 0) && !busy && !busy_nm;
    end
    if (!done) fail_now(name, $sformatf("timeout, %0d transfers / %0d responses outstanding",
                                        exp_trans.size(), exp_rsp.size()));
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_lw();
    pt(32'h100, 1'b0, 4'hF, 32'h0, 2'b00);
    pr(32'hDEADBEEF, 1'b0, 1'b0);
    req(32'h100, 1'b0, 2'b10, 1'b0, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rsp(32'hDEADBEEF, 1'b0);
    wait_idle("t1_aligned_lw");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_trans_valid", trans_valid, 0);
    chk("rst_resp_valid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err_mis", {err, mis}, 0);
    chk("rst_ready_follows_lo", ready, 0);
    trans_ready = 1'b1;
    #1;
    chk("rst_ready_follows_hi", ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. aligned word load
    test_aligned_lw();

    // 2. split half load with sign extension, first response during ISSUE2
    pt(32'h200, 1'b0, 4'h8, 32'h0, 2'b00);
    pt(32'h204, 1'b0, 4'h1, 32'h0, 2'b00);
    pr(32'hFFFFCDAB, 1'b0, 1'b1);
    req(32'h203, 1'b0, 2'b01, 1'b1, 32'h0, 2'b00);
    rsp(32'hAB000000, 1'b0);
    rsp(32'h000000CD, 1'b0);
    wait_idle("t2_split_lh");

    // 3. split bufferable store with transfer 2 stalled
    pt(32'h300, 1'b1, 4'hC, 32'h33441122, 2'b01);
    pt(32'h304, 1'b1, 4'h3, 32'h33441122, 2'b01);
    pr(32'h0, 1'b0, 1'b1);
    req(32'h302, 1'b1, 2'b10, 1'b0, 32'h11223344, 2'b01);
    trans_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    trans_ready = 1'b1;
    rsp(32'h12345678, 1'b0);
    rsp(32'h9ABCDEF0, 1'b0);
    wait_idle("t3_split_sw");

    // 4. address wrap, error on first part
    pt(32'hFFFFFFFC, 1'b0, 4'hE, 32'h0, 2'b00);
    pt(32'h00000000, 1'b0, 4'h1, 32'h0, 2'b00);
    pr(32'h88112233, 1'b1, 1'b1);
    req(32'hFFFFFFFD, 1'b0, 2'b10, 1'b0, 32'h0, 2'b00);
    rsp(32'h11223344, 1'b1);
    rsp(32'h55667788, 1'b0);
    wait_idle("t4_wrap_err");

    // Aligned sub-word loads/stores and aligned error
    pt(32'h100, 1'b0, 4'h4, 32'h0, 2'b00);
    pr(32'h000000A5, 1'b0, 1'b0);
    req(32'h102, 1'b0, 2'b00, 1'b0, 32'h0, 2'b00);
    rsp(32'h00A50000, 1'b0);
    wait_idle("t_lbu");

    pt(32'h100, 1'b0, 4'h2, 32'h0, 2'b00);
    pr(32'hFFFFFF80, 1'b0, 1'b0);
    req(32'h101, 1'b0, 2'b00, 1'b1, 32'h0, 2'b00);
    rsp(32'h00008000, 1'b0);
    wait_idle("t_lb_sext");

    pt(32'h400, 1'b0, 4'hC, 32'h0, 2'b00);
    pr(32'h0000BEEF, 1'b0, 1'b0);
    req(32'h402, 1'b0, 2'b01, 1'b0, 32'h0, 2'b00);
    rsp(32'hBEEF0000, 1'b0);
    wait_idle("t_lhu");

    pt(32'h100, 1'b1, 4'h8, 32'hA5000000, 2'b00);
    pr(32'h0, 1'b0, 1'b0);
    req(32'h103, 1'b1, 2'b00, 1'b0, 32'h000000A5, 2'b00);
    rsp(32'hFFFFFFFF, 1'b0);
    wait_idle("t_sb");

    pt(32'h500, 1'b0, 4'hF, 32'h0, 2'b00);
    pr(32'hCAFEF00D, 1'b1, 1'b0);
    req(32'h500, 1'b0, 2'b10, 1'b0, 32'h0, 2'b00);
    rsp(32'hCAFEF00D, 1'b1);
    wait_idle("t_lw_err");

    // 5. misaligned rejected when splitting is disabled
    exp_rsp_nm.push_back('{rdata: 32'h0, err: 1'b1, mis: 1'b1});
    addr = 32'h1; we = 1'b0; size = 2'b10; sext = 1'b0; wdata = '0; memtype = '0;
    valid_nm = 1'b1;
    #1;
    chk("nm_ready_on_reject", ready_nm, 1);
    @(posedge clk); #1;
    valid_nm = 1'b0;
    @(negedge clk);
    chk("nm_resp_next_cycle", rvalid_nm, 1);
    @(posedge clk); #1;
    wait_idle("t5_reject");

    // 6. reset while holding transfer 2
    pt(32'h600, 1'b0, 4'h8, 32'h0, 2'b00);
    pt(32'h604, 1'b0, 4'h7, 32'h0, 2'b00);
    req(32'h603, 1'b0, 2'b10, 1'b0, 32'h0, 2'b00);
    trans_ready = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_trans_valid", trans_valid, 0);
    exp_trans.delete();
    exp_rsp.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    trans_ready = 1'b1;
    @(posedge clk); #1;
    test_aligned_lw();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
